// File: rtl/expr_eval_arbiter.sv
// ============================================================================
// expr_eval_arbiter : buffers one expression from one of two requesters, then
//                     bursts it into a shared serial evaluator and returns result
// Revision: 1.0
// ============================================================================
`default_nettype none

module expr_eval_arbiter #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [1:0]  req_valid,
  input  logic [15:0] req_data,
  input  logic [1:0]  req_last,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ack,
  output logic [7:0]  rsp_res,
  output logic        rsp_ok,
  output logic        rsp_ovf,
  output logic        ev_clr,
  output logic [7:0]  ev_in,
  input  logic        ev_out,
  input  logic [7:0]  ev_res
);

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_LOAD     = 3'd1;
  localparam logic [2:0] c_FEED     = 3'd2;
  localparam logic [2:0] c_RESULT   = 3'd3;
  localparam logic [2:0] c_DONE_SET = 3'd4;
  localparam logic [2:0] c_DONE     = 3'd5;

  localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] c_ONE   = (AW+1)'(1);

  logic [2:0]    state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_grant_q, last_grant_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    rsp_res_q, rsp_res_d;
  logic          rsp_ok_q, rsp_ok_d;
  logic          rsp_ovf_q, rsp_ovf_d;

  logic [7:0]    mem_q [DEPTH];

  logic          w_gvalid;
  logic          w_glast;
  logic [7:0]    w_gdata;
  logic          w_full;
  logic          w_wr_en;
  logic          w_feed_end;

  assign w_gvalid   = grant_q ? req_valid[1] : req_valid[0];
  assign w_glast    = grant_q ? req_last[1]  : req_last[0];
  assign w_gdata    = grant_q ? req_data[15:8] : req_data[7:0];
  assign w_full     = (count_q == c_DEPTH);
  assign w_wr_en    = (state_q == c_LOAD) && w_gvalid && !w_full;
  assign w_feed_end = ({1'b0, idx_q} == (count_q - c_ONE));

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    count_d      = count_q;
    idx_d        = idx_q;
    ovf_d        = ovf_q;
    rsp_res_d    = rsp_res_q;
    rsp_ok_d     = rsp_ok_q;
    rsp_ovf_d    = rsp_ovf_q;

    case (state_q)
      c_IDLE: begin
        if (req_valid != 2'b00) begin
          // On a tie, the requester not served last time wins.
          if (req_valid == 2'b11) begin
            grant_d = ~last_grant_q;
          end else begin
            grant_d = req_valid[1];
          end
          last_grant_d = grant_d;
          count_d      = '0;
          ovf_d        = 1'b0;
          state_d      = c_LOAD;
        end
      end

      c_LOAD: begin
        if (w_gvalid) begin
          if (w_full) begin
            ovf_d = 1'b1;
          end else begin
            count_d = count_q + c_ONE;
          end
          if (w_glast) begin
            if (w_full || ovf_q) begin
              state_d = c_DONE_SET;
            end else begin
              idx_d   = '0;
              state_d = c_FEED;
            end
          end
        end
      end

      c_FEED: begin
        idx_d = idx_q + 1'b1;
        if (w_feed_end) begin
          state_d = c_RESULT;
        end
      end

      c_RESULT: begin
        // Evaluator clear only lands at the next edge, so its outputs are still valid here.
        rsp_res_d = ev_res;
        rsp_ok_d  = ev_out;
        rsp_ovf_d = 1'b0;
        state_d   = c_DONE;
      end

      c_DONE_SET: begin
        rsp_res_d = 8'h00;
        rsp_ok_d  = 1'b0;
        rsp_ovf_d = 1'b1;
        state_d   = c_DONE;
      end

      c_DONE: begin
        if (grant_q ? rsp_ack[1] : rsp_ack[0]) begin
          state_d = c_IDLE;
        end
      end

      default: begin
        state_d = c_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q      <= c_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      count_q      <= '0;
      idx_q        <= '0;
      ovf_q        <= 1'b0;
      rsp_res_q    <= 8'h00;
      rsp_ok_q     <= 1'b0;
      rsp_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      ovf_q        <= ovf_d;
      rsp_res_q    <= rsp_res_d;
      rsp_ok_q     <= rsp_ok_d;
      rsp_ovf_q    <= rsp_ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      mem_q[count_q[AW-1:0]] <= w_gdata;
    end
  end

  assign req_ready = (state_q == c_LOAD) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_valid = (state_q == c_DONE) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_res   = rsp_res_q;
  assign rsp_ok    = rsp_ok_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign ev_clr    = (state_q != c_FEED);
  assign ev_in     = (state_q == c_FEED) ? mem_q[idx_q] : 8'h00;

endmodule

`default_nettype wire

// File: doc/expr_eval_arbiter.md
Name: expr_eval_arbiter

Overview:
- Shares one serial expression evaluator between two requesters. The evaluator consumes one ASCII char per clock, has an active-high sync clear, and outputs a validity flag plus an 8-bit result.
- Each requester streams an ASCII expression with valid/ready/last. The block buffers the whole expression so gaps cannot corrupt evaluation. It then clears the evaluator, bursts the chars back-to-back, captures the evaluator's out/res and returns them to the granted requester.
- Sits between the front-end char sources and the evaluator instance.

Parameters:
- DEPTH, 16, expression buffer size in chars (power of 2, at least 2).
- AW, 4, log2(DEPTH); index width. Count width is AW+1.

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  reset: one clock; reset is synchronous and active-low.
- req_valid  in  2  per-requester char valid.
- req_data  in  16  chars; requester i uses bits [8i+7:8i].
- req_last  in  2  char is the final char of the expression.
- req_ready  out  2  per-requester char accept.
- rsp_valid  out  2  result available for requester i; held until ack.
- rsp_ack  in  2  requester i takes the result.
- rsp_res  out  8  evaluator result captured.
- rsp_ok  out  1  evaluator out flag captured.
- rsp_ovf  out  1  expression exceeded DEPTH; result invalid.
- ev_clr  out  1  evaluator clear, active-high.
- ev_in  out  8  char to evaluator.
- ev_out  in  1  evaluator valid flag. It reflects chars consumed at prior edges.
- ev_res  in  8  evaluator result, same timing as ev_out.

Behaviour:
- Reset (clr=0 at an edge), including mid-operation: state IDLE, req_ready=0, rsp_valid=0, rsp_res=0, rsp_ok=0, rsp_ovf=0, ev_clr=1, ev_in=0, count=0, last_grant=1. Requester 0 therefore wins the first tie.
- ev_clr=1 in every state except FEED. ev_in=0 outside FEED.
- IDLE:
  - If any req_valid is set, grant one requester: the sole requester, or when both request, the one not equal to last_grant.
  - Record grant g, set last_grant=g, count=0, ovf=0, then go to LOAD.
  - No char is accepted in IDLE.
- LOAD:
  - req_ready[g]=1; the other ready bit is 0.
  - On req_valid[g]: if count<DEPTH, write buf[count] and increment count; otherwise drop the char and set ovf=1.
  - If req_last[g] is also set: go to DONE_SET with ovf=1 if overflow occurred, otherwise go to FEED with idx=0.
  - Exactly DEPTH chars ending in last is not an overflow.
- FEED:
  - ev_clr=0, ev_in=buf[idx], idx increments every cycle.
  - After the cycle presenting buf[count-1], go to RESULT.
  - An expression of N chars occupies exactly N consecutive FEED cycles.
- RESULT (one cycle):
  - ev_clr=1.
  - Register rsp_res=ev_res and rsp_ok=ev_out. The evaluator's sync clear takes effect only at the following edge, so the sample is valid.
  - Go to DONE.
- DONE_SET (overflow path): rsp_res=0, rsp_ok=0, rsp_ovf=1, then go to DONE.
- DONE:
  - rsp_valid[g]=1; rsp_res, rsp_ok and rsp_ovf are held stable.
  - On rsp_ack[g], clear rsp_valid and go to IDLE. rsp_ack of the non-granted requester is ignored.
- Latency: if last is accepted at edge k, FEED covers cycles k+1..k+N, RESULT is cycle k+N+1, and rsp_valid rises in cycle k+N+2.
- A requester's valid asserted during another's transaction waits with ready=0. Its data must be held by the source.
- Gaps (req_valid=0) during LOAD are allowed and do not affect evaluation.

Test Plan:
- Evaluator model for the bench: accepts digit (op digit)* with op in {+,*}, evaluates left to right mod 256, out=1 iff the sequence is well-formed.
- Req0 sends "1","+","2" (last on "2") with no gaps -> ev_in sees 0x31,0x2B,0x32 on 3 consecutive cycles with ev_clr=0; rsp_valid[0] rises 5 cycles after last is accepted; rsp_res=3, rsp_ok=1, rsp_ovf=0.
- Req0 and req1 both valid in IDLE after reset -> req0 is granted first; after ack, req1's "9","*","9" -> rsp_valid[1], rsp_res=81; the next tie goes to req0.
- Req1 sends "7","+" with a 3-cycle valid gap between chars -> FEED is still 2 contiguous cycles; rsp_ok=0.
- DEPTH=16: send 16 chars then 1 more with last -> no FEED cycles occur, rsp_ovf=1, rsp_res=0, rsp_ok=0. Also send exactly 16 chars ending in last -> rsp_ovf=0.
- Assert clr=0 for one edge mid-FEED -> next cycle is IDLE with ev_clr=1, all rsp/req_ready outputs 0; a subsequent "4" from req0 -> rsp_res=4, rsp_ok=1.
- Hold rsp_ack[0]=0 for 10 cycles in DONE, and pulse rsp_ack[1] during that time -> rsp_valid[0] and its data stay stable, and rsp_ack[1] is ignored.
